memi_load_ctrl: RTL

Sequencer for the double-banked instruction memory (two banks, each two 128-bit RAMs selected by address LSB, with a BANK select).
- Streams 128-bit instruction words from a loader into the inactive (write) bank.
- Serves 256-bit line fetches from the active (read) bank.
- Swaps banks on request once loading is complete, so the array sequencer can run one program while the next one is loaded.

---
 rtl/memi_load_ctrl_if.sv | 43 ++++
 rtl/memi_load_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/memi_load_ctrl_if.sv
// Loader, fetch and memory-side signals of the instruction-memory sequencer.
// The sequencer uses the slave view; loader/fetcher/memory models use master.
interface memi_load_ctrl_if #(
    parameter int ADRS = 14,
    parameter int BITS = 128,
    parameter int LENW = 15
);
    logic              LD_START;
    logic [ADRS-1:0]   LD_BASE;
    logic [LENW-1:0]   LD_LEN;
    logic              LD_VALID;
    logic [BITS-1:0]   LD_DATA;
    logic              LD_READY;
    logic              LD_BUSY;
    logic              LD_DONE;
    logic              SWAP_REQ;
    logic              SWAP_ACK;
    logic              FE_REQ;
    logic [ADRS-2:0]   FE_ADDR;
    logic              FE_VALID;
    logic [2*BITS-1:0] FE_DATA;
    logic [ADRS-1:0]   RA;
    logic [ADRS-1:0]   WA;
    logic [2*BITS-1:0] DW;
    logic              RCEB;
    logic              WCEB;
    logic              BANK;
    logic [2*BITS-1:0] QW;

    modport slave (
        input  LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, SWAP_REQ,
               FE_REQ, FE_ADDR, QW,
        output LD_READY, LD_BUSY, LD_DONE, SWAP_ACK, FE_VALID, FE_DATA,
               RA, WA, DW, RCEB, WCEB, BANK
    );

    modport master (
        output LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, SWAP_REQ,
               FE_REQ, FE_ADDR, QW,
        input  LD_READY, LD_BUSY, LD_DONE, SWAP_ACK, FE_VALID, FE_DATA,
               RA, WA, DW, RCEB, WCEB, BANK
    );
endinterface

// File: rtl/memi_load_ctrl.sv
// Double-banked instruction memory sequencer: loads the inactive bank,
// serves line fetches from the active bank and swaps banks on request.
module memi_load_ctrl #(
    parameter int ADRS = 14,
    parameter int BITS = 128,
    parameter int LENW = 15
) (
    input  logic           CLK,
    input  logic           RST,
    memi_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOADED = 2'd2
    } state_t;

    localparam logic [ADRS-1:0] PTR_ONE  = {{(ADRS-1){1'b0}}, 1'b1};
    localparam logic [LENW-1:0] CNT_ONE  = {{(LENW-1){1'b0}}, 1'b1};
    localparam logic [LENW-1:0] CNT_ZERO = {LENW{1'b0}};

    state_t          state_r;
    state_t          state_s;
    logic            bank_r;
    logic [ADRS-1:0] ptr_r;
    logic [LENW-1:0] cnt_r;
    logic            fe_valid_r;
    logic            ld_ready_s;
    logic            beat_s;
    logic            swap_ack_s;
    logic            start_s;

    // Next-state and handshake decode; a pending swap always beats a new load
    always_comb begin
        state_s    = state_r;
        ld_ready_s = 1'b0;
        beat_s     = 1'b0;
        swap_ack_s = 1'b0;
        start_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOADED: begin
                if (bus.SWAP_REQ) begin
                    swap_ack_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (bus.LD_START) begin
                    start_s = 1'b1;
                    state_s = (bus.LD_LEN != CNT_ZERO) ? ST_LOAD : ST_LOADED;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                ld_ready_s = 1'b1;
                if (bus.LD_VALID) begin
                    beat_s  = 1'b1;
                    state_s = (cnt_r == CNT_ONE) ? ST_LOADED : ST_LOAD;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bank select, load pointer/count and fetch-valid registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            bank_r     <= 1'b0;
            ptr_r      <= {ADRS{1'b0}};
            cnt_r      <= CNT_ZERO;
            fe_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            fe_valid_r <= bus.FE_REQ;
            if (swap_ack_s) begin
                bank_r <= ~bank_r;
            end
            if (start_s) begin
                ptr_r <= bus.LD_BASE;
                cnt_r <= bus.LD_LEN;
            end else if (beat_s) begin
                ptr_r <= ptr_r + PTR_ONE;
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    assign bus.LD_READY = ld_ready_s;
    assign bus.LD_BUSY  = (state_r == ST_LOAD);
    assign bus.LD_DONE  = (state_r == ST_LOADED);
    assign bus.SWAP_ACK = swap_ack_s;
    assign bus.WCEB     = ~beat_s;
    assign bus.WA       = ptr_r;
    assign bus.DW       = {bus.LD_DATA, bus.LD_DATA};
    // The memory realigns the two RAM halves of a line itself
    assign bus.RA       = {bus.FE_ADDR, 1'b0};
    assign bus.RCEB     = ~bus.FE_REQ;
    assign bus.FE_VALID = fe_valid_r;
    assign bus.FE_DATA  = bus.QW;
    assign bus.BANK     = bank_r;

endmodule
